// File: rtl/ret_addr_stack.sv
// ret_addr_stack: return-address stack predictor with per-branch checkpoint restore
module ret_addr_stack #(
   parameter int DEPTH    = 16,
   parameter int IP_WIDTH = 48,
   parameter int NCKPT    = 8,
   localparam int PTR_W   = $clog2(DEPTH),
   localparam int TAG_W   = $clog2(NCKPT)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                stall,
   input  logic                push,
   input  logic                pop,
   input  logic [IP_WIDTH-1:0] push_addr,
   input  logic                ckpt_en,
   input  logic [TAG_W-1:0]    ckpt_tag,
   input  logic                flush,
   input  logic [TAG_W-1:0]    flush_tag,
   output logic [IP_WIDTH-1:0] top_addr,
   output logic                top_valid,
   output logic [PTR_W:0]      count,
   output logic                overflow,
   output logic                underflow
);
   localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);
   logic [IP_WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]    ck_tos_q [NCKPT];
   logic [PTR_W:0]      ck_cnt_q [NCKPT];
   logic [IP_WIDTH-1:0] ck_top_q [NCKPT];
   logic [NCKPT-1:0]    ck_vld_q, ck_vld_d;
   logic [PTR_W-1:0]    tos_q, tos_d;
   logic [PTR_W:0]      count_q, count_d;
   logic                ovf_q, ovf_d, unf_q, unf_d;
   logic                mem_we, ck_we;
   logic [PTR_W-1:0]    mem_wa;
   logic [IP_WIDTH-1:0] mem_wd, push_data;
   assign push_data = {push_addr[IP_WIDTH-1:1], 1'b0};
   assign top_valid = count_q != '0;
   assign top_addr  = top_valid ? mem_q[tos_q] : '0;
   assign count     = count_q;
   assign overflow  = ovf_q;
   assign underflow = unf_q;
   // next-state: flush restore beats stall, stall freezes push/pop/checkpoint
   always_comb begin
      tos_d    = tos_q;
      count_d  = count_q;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
      ck_vld_d = ck_vld_q;
      ck_we    = 1'b0;
      mem_we   = 1'b0;
      mem_wa   = tos_q;
      mem_wd   = push_data;
      if (flush) begin
         ck_vld_d = '0;
         if (ck_vld_q[flush_tag]) begin
            tos_d   = ck_tos_q[flush_tag];
            count_d = ck_cnt_q[flush_tag];
            mem_we  = 1'b1;
            mem_wa  = ck_tos_q[flush_tag];
            mem_wd  = ck_top_q[flush_tag];
         end else begin
            tos_d   = '0;
            count_d = '0;
         end
      end else if (!stall) begin
         if (ckpt_en) begin
            ck_we              = 1'b1;
            ck_vld_d[ckpt_tag] = 1'b1;
         end
         if (push && pop) begin
            mem_we  = 1'b1;
            count_d = (count_q == '0) ? (PTR_W+1)'(1) : count_q;
         end else if (push) begin
            tos_d   = tos_q + 1'b1;
            mem_we  = 1'b1;
            mem_wa  = tos_q + 1'b1;
            count_d = (count_q == FULL) ? count_q : count_q + 1'b1;
            ovf_d   = count_q == FULL;
         end else if (pop) begin
            tos_d   = (count_q != '0) ? tos_q - 1'b1 : tos_q;
            count_d = (count_q != '0) ? count_q - 1'b1 : count_q;
            unf_d   = count_q == '0;
         end
      end
   end
   // control state with asynchronous active-low reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tos_q    <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
         ck_vld_q <= '0;
      end else begin
         tos_q    <= tos_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
         ck_vld_q <= ck_vld_d;
      end
   end
   // stack entries, not reset; top_addr is gated by count instead
   always_ff @(posedge clk) begin
      if (mem_we) mem_q[mem_wa] <= mem_wd;
   end
   // checkpoint payload snapshots state before any same-cycle push/pop
   always_ff @(posedge clk) begin
      if (ck_we) begin
         ck_tos_q[ckpt_tag] <= tos_q;
         ck_cnt_q[ckpt_tag] <= count_q;
         ck_top_q[ckpt_tag] <= mem_q[tos_q];
      end
   end
endmodule
